// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for the slice-serial ALU engine.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_XOR  = 3'b000,
    OP_XNOR = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_OR   = 3'b100,
    OP_NOR  = 3'b101,
    OP_AND  = 3'b110,
    OP_SLT  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Only add, sub and the 111 code carry between bit positions.
  function automatic logic uses_carry(input logic [2:0] s);
    return (s == OP_ADD) || (s == OP_SUB) || (s == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_cell.sv
// One-bit ALU cell: result bit d plus generate/propagate for the external carry chain.
module alu_cell
  import alu_pkg::*;
(
  input  logic [2:0] s,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  output logic       d,
  output logic       g,
  output logic       p
);

  logic bint;
  logic cint;

  always_comb begin
    bint = b ^ s[0];
    cint = uses_carry(s) & c;
    g    = a & bint;
    p    = a | bint;
    unique case (s)
      3'b000, 3'b001: d = a ^ bint;
      3'b100:         d = a | b;
      3'b101:         d = ~(a | b);
      3'b110:         d = a & b;
      default:        d = a ^ bint ^ cint;
    endcase
  end

endmodule

// File: rtl/alu_slice.sv
// SLICE-bit group of alu_cells with an internal ripple carry chain.
module alu_slice
  import alu_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [2:0]       s,
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] d,
  output logic             cout,
  output logic             cmsb
);

  logic [SLICE:0]   c;
  logic [SLICE-1:0] g;
  logic [SLICE-1:0] p;
  logic             carry_en;

  assign carry_en = uses_carry(s);
  assign c[0]     = cin;

  for (genvar gi = 0; gi < SLICE; gi++) begin : g_cell
    alu_cell u_cell (
      .s(s),
      .a(a[gi]),
      .b(b[gi]),
      .c(c[gi]),
      .d(d[gi]),
      .g(g[gi]),
      .p(p[gi])
    );
    assign c[gi+1] = g[gi] | (p[gi] & c[gi] & carry_en);
  end

  assign cout = c[SLICE];
  assign cmsb = c[SLICE-1];

endmodule

// File: rtl/alu_serial_engine.sv
// Slice-serial ALU: one SLICE-bit slice per cycle, carry closed through a register.
// Define ALU_SLT_EN to make op 111 a signed set-less-than; otherwise it returns zero.
module alu_serial_engine
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if (WIDTH % SLICE != 0) begin : g_width_check
    $error("alu_serial_engine: WIDTH must be a multiple of SLICE");
  end

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d;
  logic             cy_q, cy_d, zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d;

  logic [SLICE-1:0] a_slice, b_slice, d_slice;
  logic             slice_cout, slice_cmsb;
  logic [WIDTH-1:0] full, final_r;
  logic             flag_c, flag_v, last;

  always_comb begin
    a_slice = a_q[int'(idx_q)*SLICE +: SLICE];
    b_slice = b_q[int'(idx_q)*SLICE +: SLICE];
  end

  alu_slice #(.SLICE(SLICE)) u_slice (
    .s(op_q),
    .a(a_slice),
    .b(b_slice),
    .cin(cy_q),
    .d(d_slice),
    .cout(slice_cout),
    .cmsb(slice_cmsb)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cy_d     = cy_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;

    full = acc_q;
    full[int'(idx_q)*SLICE +: SLICE] = d_slice;
    last    = (int'(idx_q) == NSLICE - 1);
    final_r = full;
    flag_c  = 1'b0;
    flag_v  = 1'b0;
    if (uses_carry(op_q)) begin
      flag_c = slice_cout;
      flag_v = slice_cmsb ^ slice_cout;
    end
    // Op 111 still runs the subtract chain so latency does not depend on the build.
    if (op_q == OP_SLT) begin
`ifdef ALU_SLT_EN
      final_r = {{(WIDTH-1){1'b0}}, full[WIDTH-1] ^ flag_v};
`else
      final_r = '0;
      flag_c  = 1'b0;
      flag_v  = 1'b0;
`endif
    end

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          idx_d   = '0;
          op_d    = op;
          a_d     = a;
          b_d     = b;
          cy_d    = op[0];
        end
      end
      RUN: begin
        acc_d = full;
        cy_d  = slice_cout;
        idx_d = idx_q + 1'b1;
        if (last) begin
          state_d  = DONE;
          result_d = final_r;
          zero_d   = (final_r == '0);
          carry_d  = flag_c;
          ovf_d    = flag_v;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cy_q     <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cy_q     <= cy_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_serial_engine.sv
// Self-checking bench for alu_serial_engine: arithmetic reference model, directed and random ops.
module tb_alu_serial_engine;
  import alu_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] r;
    logic         z;
    logic         c;
    logic         v;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero, carry, ovf;

  int   n_cmp = 0;
  int   n_err = 0;
  logic exp_valid = 1'b0;
  exp_t exp_q;

  always #5 clk = ~clk;

  alu_serial_engine #(.WIDTH(W), .SLICE(8)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op(op),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .zero(zero),
    .carry(carry),
    .ovf(ovf)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: plain two's-complement arithmetic on the operands.
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t   e;
    logic [W:0] s;
    e.r = '0;
    e.c = 1'b0;
    e.v = 1'b0;
    case (o)
      3'b000: e.r = x ^ y;
      3'b001: e.r = ~(x ^ y);
      3'b010: begin
        s   = {1'b0, x} + {1'b0, y};
        e.r = s[W-1:0];
        e.c = s[W];
        e.v = (x[W-1] == y[W-1]) && (e.r[W-1] != x[W-1]);
      end
      3'b011: begin
        s   = {1'b0, x} + {1'b0, ~y} + 1;
        e.r = s[W-1:0];
        e.c = s[W];
        e.v = (x[W-1] != y[W-1]) && (e.r[W-1] != x[W-1]);
      end
      3'b100: e.r = x | y;
      3'b101: e.r = ~(x | y);
      3'b110: e.r = x & y;
      default: begin
`ifdef ALU_SLT_EN
        s   = {1'b0, x} + {1'b0, ~y} + 1;
        e.c = s[W];
        e.v = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
        e.r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
`else
        e.r = '0;
`endif
      end
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  // Compare process: result and flags on every cycle the result is valid.
  always @(negedge clk) begin
    if (exp_valid) begin
      check("in_ready_busy", in_ready, 0);
      if (out_valid) begin
        check("result", result, exp_q.r);
        check("zero", zero, exp_q.z);
        check("carry", carry, exp_q.c);
        check("ovf", ovf, exp_q.v);
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input int hold);
    int k;
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("in_ready_wait", in_ready, 1);
    op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
    exp_q = model(o, x, y);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_valid = 1'b1;
    op = 3'($urandom); a = $urandom; b = $urandom;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      check("latency", out_valid, (i == 4));
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    exp_valid = 1'b0;
    @(negedge clk);
    check("post_valid", out_valid, 0);
    check("post_ready", in_ready, 1);
    $display("op=%b a=%h b=%h -> result=%h z=%b c=%b v=%b", o, x, y, exp_q.r, exp_q.z, exp_q.c, exp_q.v);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 6))
      0: v = 32'h0000_0000;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h7FFF_FFFF;
      3: v = 32'h8000_0000;
      4: v = 32'h0000_0001;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    exp_t e;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", {zero, carry, ovf}, 0);
    rst = 1'b0;

    // Hand-computed values pin the reference model.
    e = model(3'b010, 32'h7FFF_FFFF, 32'h0000_0001);
    check("pin_add", {e.r, e.z, e.c, e.v}, {32'h8000_0000, 3'b001});
    e = model(3'b011, 32'd5, 32'd5);
    check("pin_sub0", {e.r, e.z, e.c, e.v}, {32'h0, 3'b110});
    e = model(3'b011, 32'd0, 32'd1);
    check("pin_subm1", {e.r, e.c}, {32'hFFFF_FFFF, 1'b0});
    e = model(3'b110, 32'hF0F0_F0F0, 32'hFF00_FF00);
    check("pin_and", e.r, 32'hF000_F000);
    e = model(3'b111, 32'hFFFF_FFFF, 32'h1);
`ifdef ALU_SLT_EN
    check("pin_slt", e.r, 32'h1);
`else
    check("pin_slt", {e.r, e.z}, {32'h0, 1'b1});
`endif

    issue(3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    issue(3'b011, 32'd5, 32'd5, 0);
    issue(3'b011, 32'd0, 32'd1, 1);
    issue(3'b101, 32'd0, 32'd0, 0);
    issue(3'b110, 32'hF0F0_F0F0, 32'hFF00_FF00, 3);
    issue(3'b111, 32'hFFFF_FFFF, 32'h1, 0);
    issue(3'b000, 32'h1234_5678, 32'h0F0F_0F0F, 0);
    issue(3'b001, 32'h1234_5678, 32'h0F0F_0F0F, 0);
    issue(3'b100, 32'h1234_5678, 32'h0F0F_0F0F, 0);

    // Reset during RUN discards the operation.
    op = 3'b010; a = 32'd100; b = 32'd200; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", out_valid, 0);
    check("midrst_ready", in_ready, 1);
    check("midrst_result", result, 0);
    repeat (4) @(negedge clk);
    check("midrst_no_emit", out_valid, 0);
    $display("reset during RUN: in-flight op discarded");
    issue(3'b010, 32'd1, 32'd2, 0);

    for (int n = 0; n < 40; n++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick(), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no completion, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
